// File: rtl/shot_fire_controller.sv
// Player shot sequencer: edge-detected fire, one-cycle launch/kill pulses,
// retirement on collision / board exit / flight timeout, then frame-counted reload.
module shot_fire_controller #(
  parameter int unsigned RELOAD_FRAMES     = 60,
  parameter int unsigned MAX_FLIGHT_FRAMES = 90,
  parameter int unsigned BOARD_LEFT        = 32,
  parameter int unsigned BOARD_RIGHT       = 608,
  parameter int unsigned BOARD_TOP         = 160,
  parameter int unsigned BOARD_BOTTOM      = 464,
  parameter logic [15:0] SHOTS_INIT        = 16'h0000
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic        fire_pressed,
  input  logic        player_awake,
  input  logic        fireCollision,
  input  logic        shot_alive,
  input  logic [10:0] shotX,
  input  logic [10:0] shotY,
  output logic        launch,
  output logic        kill,
  output logic        shot_ready,
  output logic [1:0]  kill_cause,
  output logic [7:0]  reload_left,
  output logic [15:0] shots_fired
);

  typedef enum logic [1:0] {
    ST_READY  = 2'b00,
    ST_FLYING = 2'b01,
    ST_RELOAD = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE      = 2'b00,
    CAUSE_COLLISION = 2'b01,
    CAUSE_BOUNDS    = 2'b10,
    CAUSE_TIMEOUT   = 2'b11
  } cause_t;

  localparam logic [7:0]  RELOAD_INIT = 8'(RELOAD_FRAMES);
  localparam logic [7:0]  MAX_FLIGHT  = 8'(MAX_FLIGHT_FRAMES);
  localparam logic [10:0] LEFT_X      = 11'(BOARD_LEFT);
  localparam logic [10:0] RIGHT_X     = 11'(BOARD_RIGHT);
  localparam logic [10:0] TOP_Y       = 11'(BOARD_TOP);
  localparam logic [10:0] BOTTOM_Y    = 11'(BOARD_BOTTOM);

  state_t      state_q, state_d;
  cause_t      cause_q, cause_d, retire_cause;
  logic        fire_prev_q, rise_q;
  logic        launch_q, launch_d;
  logic        kill_q, kill_d;
  logic [7:0]  reload_q, reload_d;
  logic [15:0] shots_q, shots_d;
  logic [7:0]  flight_q, flight_d;
  logic [1:0]  age_q, age_d;
  logic        out_of_board;

  // fire_prev resets high so a key held through reset must be released before it can fire.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      fire_prev_q <= 1'b1;
      rise_q      <= 1'b0;
    end else begin
      fire_prev_q <= fire_pressed;
      rise_q      <= fire_pressed & ~fire_prev_q;
    end
  end

  assign out_of_board = shot_alive &&
                        (shotX < LEFT_X || shotX > RIGHT_X || shotY < TOP_Y || shotY > BOTTOM_Y);

  // age_q counts FLYING cycles up to 2: bounds need age>=1, self-clear detection needs age>=2.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    state_d      = state_q;
    cause_d      = cause_q;
    launch_d     = 1'b0;
    kill_d       = 1'b0;
    reload_d     = reload_q;
    shots_d      = shots_q;
    flight_d     = flight_q;
    age_d        = age_q;
    retire_cause = CAUSE_NONE;

    case (state_q)
      ST_READY: begin
        if (rise_q && player_awake) begin
          launch_d = 1'b1;
          flight_d = 8'd0;
          age_d    = 2'd0;
          cause_d  = CAUSE_NONE;
          shots_d  = shots_q + 16'd1;
          state_d  = ST_FLYING;
        end
      end

      ST_FLYING: begin
        if (fireCollision)                     retire_cause = CAUSE_COLLISION;
        else if (age_q != 2'd0 && out_of_board) retire_cause = CAUSE_BOUNDS;
        else if (flight_q == MAX_FLIGHT)        retire_cause = CAUSE_TIMEOUT;

        if (retire_cause != CAUSE_NONE) begin
          kill_d   = 1'b1;
          cause_d  = retire_cause;
          reload_d = RELOAD_INIT;
          state_d  = ST_RELOAD;
        end else if (age_q == 2'd2 && !shot_alive) begin
          reload_d = RELOAD_INIT;
          state_d  = ST_RELOAD;
        end else begin
          if (startOfFrame && flight_q != 8'hFF) flight_d = flight_q + 8'd1;
          if (age_q != 2'd2)                     age_d    = age_q + 2'd1;
        end
      end

      ST_RELOAD: begin
        if (reload_q == 8'd0)  state_d  = ST_READY;
        else if (startOfFrame) reload_d = reload_q - 8'd1;
      end

      default: state_d = ST_READY;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q  <= ST_READY;
      cause_q  <= CAUSE_NONE;
      launch_q <= 1'b0;
      kill_q   <= 1'b0;
      reload_q <= 8'd0;
      shots_q  <= SHOTS_INIT;
      flight_q <= 8'd0;
      age_q    <= 2'd0;
    end else begin
      state_q  <= state_d;
      cause_q  <= cause_d;
      launch_q <= launch_d;
      kill_q   <= kill_d;
      reload_q <= reload_d;
      shots_q  <= shots_d;
      flight_q <= flight_d;
      age_q    <= age_d;
    end
  end

  assign launch      = launch_q;
  assign kill        = kill_q;
  assign shot_ready  = (state_q == ST_READY);
  assign kill_cause  = cause_q;
  assign reload_left = reload_q;
  assign shots_fired = shots_q;

endmodule
